// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter sharing one single-ported word memory between the
//   instruction-fetch port (if_*) and the load/store port (ls_*). One request
//   is granted at a time. The granted request is registered toward memory as
//   a one-cycle mem_valid_o pulse. The memory's ready/rdata response is
//   returned to the granted port as a one-cycle ready pulse.
//
//   Build option:
//     MEM_ARB_RR_EN  defined   -> round-robin between the two ports
//                    undefined -> fixed priority, load/store over fetch
//
//   Ports:
//     clk, rst                  clock; asynchronous active-high reset
//     if_valid_i / if_addr_i    fetch request (held until if_ready_o)
//     if_ready_o / if_rdata_o   fetch completion pulse and data
//     ls_valid_i / ls_addr_i / ls_we_i / ls_be_i / ls_wdata_i
//                               load/store request (held until ls_ready_o)
//     ls_ready_o / ls_rdata_o   load/store completion pulse and data
//     mem_valid_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o
//                               registered request toward memory
//     mem_ready_i / mem_rdata_i memory completion pulse and read data
//     gnt_o                     current owner: bit0 fetch, bit1 load/store

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = `RISCV_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = `RISCV_WORD_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      if_valid_i,
    input  logic [ADDR_WIDTH-1:0]     if_addr_i,
    output logic                      if_ready_o,
    output logic [DATA_WIDTH-1:0]     if_rdata_o,

    input  logic                      ls_valid_i,
    input  logic [ADDR_WIDTH-1:0]     ls_addr_i,
    input  logic                      ls_we_i,
    input  logic [DATA_WIDTH/8-1:0]   ls_be_i,
    input  logic [DATA_WIDTH-1:0]     ls_wdata_i,
    output logic                      ls_ready_o,
    output logic [DATA_WIDTH-1:0]     ls_rdata_o,

    output logic                      mem_valid_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_ready_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    output logic [1:0]                gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   pick_ls;

`ifdef MEM_ARB_RR_EN
    // 1 = load/store was granted last, 0 = fetch was granted last.
    logic last_ls;

    // On contention the port that was not granted last wins.
    always_comb begin
        pick_ls = ls_valid_i && (!if_valid_i || !last_ls);
    end
`else
    always_comb begin
        pick_ls = ls_valid_i;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt_o       <= '0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            if_ready_o  <= 1'b0;
            ls_ready_o  <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
`ifdef MEM_ARB_RR_EN
            last_ls     <= 1'b0;
`endif
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            mem_valid_o <= 1'b0;
            if_ready_o  <= 1'b0;
            ls_ready_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (if_valid_i || ls_valid_i) begin
                        mem_valid_o <= 1'b1;
                        state       <= ISSUE;
                        if (pick_ls) begin
                            mem_addr_o  <= ls_addr_i;
                            mem_we_o    <= ls_we_i;
                            mem_be_o    <= ls_be_i;
                            mem_wdata_o <= ls_wdata_i;
                            gnt_o       <= 2'b10;
                        end else begin
                            mem_addr_o  <= if_addr_i;
                            mem_we_o    <= 1'b0;
                            mem_be_o    <= '0;
                            mem_wdata_o <= '0;
                            gnt_o       <= 2'b01;
                        end
`ifdef MEM_ARB_RR_EN
                        last_ls <= pick_ls;
`endif
                    end
                end

                // ISSUE and WAIT differ only in mem_valid_o, which the
                // default assignment above already handles.
                ISSUE, WAIT: begin
                    if (mem_ready_i) begin
                        state <= RESP;
                        if (gnt_o[1]) begin
                            ls_rdata_o <= mem_rdata_i;
                            ls_ready_o <= 1'b1;
                        end else begin
                            if_rdata_o <= mem_rdata_i;
                            if_ready_o <= 1'b1;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end

                // Requests are not sampled here, so a requester dropping
                // valid after its ready pulse is never issued twice.
                RESP: begin
                    gnt_o <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported word memory between the core's instruction-fetch port and its load/store port. It sits between the core and a memory that answers a one-cycle `valid` pulse with a later one-cycle `ready` pulse plus read data. It grants one request at a time, registers the request toward memory and returns the response to the winning requester. Writes are forwarded for the load/store port only.

## Interface
- `ADDR_WIDTH`, default `` `RISCV_ADDR_WIDTH ``: address width of all ports.
- `DATA_WIDTH`, default `` `RISCV_WORD_WIDTH ``: word width of all data ports.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_valid_i`  in  1  fetch request; held with `if_addr_i` stable until `if_ready_o`.
- `if_addr_i`  in  ADDR_WIDTH  fetch byte address.
- `if_ready_o`  out  1  one-cycle fetch completion pulse.
- `if_rdata_o`  out  DATA_WIDTH  fetch data, valid while `if_ready_o`=1.
- `ls_valid_i`  in  1  load/store request; held with address, data and controls stable until `ls_ready_o`.
- `ls_addr_i`  in  ADDR_WIDTH  load/store byte address.
- `ls_we_i`  in  1  1 = write.
- `ls_be_i`  in  DATA_WIDTH/8  write byte enables.
- `ls_wdata_i`  in  DATA_WIDTH  write data.
- `ls_ready_o`  out  1  one-cycle load/store completion pulse.
- `ls_rdata_o`  out  DATA_WIDTH  load data, valid while `ls_ready_o`=1.
- `mem_valid_o`  out  1  one-cycle request pulse to memory.
- `mem_addr_o`  out  ADDR_WIDTH  registered address of the granted request.
- `mem_we_o`  out  1  registered write enable; 0 for fetches.
- `mem_be_o`  out  DATA_WIDTH/8  registered byte enables; 0 for fetches.
- `mem_wdata_o`  out  DATA_WIDTH  registered write data.
- `mem_ready_i`  in  1  memory completion pulse.
- `mem_rdata_i`  in  DATA_WIDTH  memory read data, sampled with `mem_ready_i`.
- `gnt_o`  out  2  current owner: bit0 = fetch, bit1 = load/store; one-hot or 0.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT and RESP.

- **IDLE**
  - If either valid is high, select a winner.
  - Latch the winner's address, `we`, `be` and `wdata` into the `mem_*_o` registers (fetch: `we`=0, `be`=0).
  - Set `gnt_o` and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `mem_valid_o`=1 for exactly this cycle.
  - If `mem_ready_i`=1 in this cycle, capture `mem_rdata_i` and go to RESP; otherwise go to WAIT.
- **WAIT**
  - `mem_valid_o`=0.
  - On `mem_ready_i`, capture `mem_rdata_i` and go to RESP.
  - There is no timeout.
- **RESP**
  - Pulse the granted port's `ready_o` for one cycle; its `rdata_o` holds the captured word. For writes, `rdata_o` carries whatever the memory returned.
  - Clear `gnt_o` at the end of the cycle and go to IDLE.
  - Requests are not sampled in RESP, so a requester that drops `valid` after seeing `ready` is never issued twice.

Other rules:
- Fixed priority (default): load/store wins over fetch when both are valid in IDLE.
- `mem_ready_i` in IDLE or RESP is ignored. This includes stray completions after a reset.
- `if_rdata_o` and `ls_rdata_o` update only in RESP for the granted port and hold their value otherwise.
- No address translation; `mem_addr_o` is the requester's byte address, unmodified.

## Timing
- Reset values:
  - state IDLE; `gnt_o`=0.
  - `mem_valid_o`, `mem_we_o`=0; `mem_be_o`=0.
  - `mem_addr_o`, `mem_wdata_o`=0.
  - `if_ready_o`, `ls_ready_o`=0.
  - `if_rdata_o`, `ls_rdata_o`=0.
- Reset mid-operation drops the in-flight request without a response. The requester must re-issue it.
- Latency, with `valid` first high in cycle 0:
  - `mem_valid_o` is high in cycle 1.
  - With a one-cycle memory, `mem_ready_i` is high in cycle 2 and `ready_o` in cycle 3.
  - With a zero-latency memory (`mem_ready_i` in ISSUE), `ready_o` is high in cycle 2.
- Throughput: one transaction per 4 cycles with a one-cycle memory. The next request is sampled in IDLE, cycle 4.
- At most one request is ever outstanding to memory.

## Configuration
- `MEM_ARB_RR_EN`
  - Defined: round-robin arbitration. A one-bit last-grant register, reset to "fetch", records the last port granted. When both ports are valid in IDLE, the port not last granted wins. A single valid port always wins.
  - Undefined: fixed priority, load/store over fetch. The last-grant register is not instantiated.

## Test plan
- Single fetch, addr 0x10, memory returns 0xDEADBEEF one cycle after `mem_valid_o` -> `mem_valid_o` in cycle 1 with `mem_addr_o`=0x10, `if_ready_o` in cycle 3 with `if_rdata_o`=0xDEADBEEF, `gnt_o`=01 during cycles 1-3.
- Store, addr 0x20, wdata 0x12345678, be 0xF -> one `mem_valid_o` pulse with `mem_we_o`=1 and `mem_be_o`=0xF, `ls_ready_o` one pulse in cycle 3, `if_ready_o` stays 0.
- Both ports valid in cycle 0 and held:
  - Fixed priority: load/store granted first; fetch completes next, with `if_ready_o` in cycle 7.
  - `MEM_ARB_RR_EN`: load/store first, then fetch, then load/store, alternating.
- Memory stalls 5 cycles in WAIT -> `mem_valid_o` single pulse only, `ready_o` exactly one cycle after `mem_ready_i`; a stray `mem_ready_i` pulse in IDLE produces no `ready_o`.
- Assert `rst` in WAIT, then pulse `mem_ready_i` after release -> all outputs at reset values, no `ready_o`, next request issues normally.
